// File: rtl/load_store_aligner_pkg.sv
// lsa_pkg: shared encodings and helpers for the load/store aligner.
//   - access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD, 2'b00 is invalid)
//   - FSM state encoding
//   - is_misaligned(): legality check for a size/lane-offset pair
package lsa_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MEM  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Offset is passed zero-extended to 3 bits so one helper serves both the
   // 4-lane and the 8-lane datapath. A word needs only 4-byte alignment, so
   // offset 4 in a 64-bit datapath is legal.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_aligner_if.sv
// load_store_aligner_if: request / memory / response bundle of the aligner.
//   slave modport  : seen by load_store_aligner
//   master modport : seen by the requester / memory model
//   req_*  : valid/ready request (we, addr, size, sign, wdata)
//   mem_*  : word-aligned memory access held until i_mem_ack
//   rsp_*  : valid/ready response (rdata, err)
// Build option LSA_ERR_COUNT_EN adds o_err_count[15:0].
interface load_store_aligner_if #(
   parameter int NBITS = 32,
   parameter int AW    = 32
);
   localparam int NLANE = NBITS / 8;

   logic             i_req_valid;
   logic             o_req_ready;
   logic             i_req_we;
   logic [AW-1:0]    i_req_addr;
   logic [1:0]       i_req_size;
   logic             i_req_sign;
   logic [NBITS-1:0] i_req_wdata;
   logic             o_mem_en;
   logic [NLANE-1:0] o_mem_we;
   logic [AW-1:0]    o_mem_addr;
   logic [NBITS-1:0] o_mem_wdata;
   logic             i_mem_ack;
   logic [NBITS-1:0] i_mem_rdata;
   logic             o_rsp_valid;
   logic             i_rsp_ready;
   logic [NBITS-1:0] o_rsp_rdata;
   logic             o_rsp_err;
`ifdef LSA_ERR_COUNT_EN
   logic [15:0]      o_err_count;
`endif

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_sign, i_req_wdata,
      input  i_mem_ack, i_mem_rdata, i_rsp_ready,
      output o_req_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      output o_rsp_valid, o_rsp_rdata, o_rsp_err
`ifdef LSA_ERR_COUNT_EN
      , output o_err_count
`endif
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_sign, i_req_wdata,
      output i_mem_ack, i_mem_rdata, i_rsp_ready,
      input  o_req_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      input  o_rsp_valid, o_rsp_rdata, o_rsp_err
`ifdef LSA_ERR_COUNT_EN
      , input o_err_count
`endif
   );

endinterface

// File: rtl/load_store_aligner_lane_fmt.sv
// lsa_lane_fmt: combinational lane formatting (little-endian).
//   size, sign, off : access size, load extension mode, byte-lane offset
//   wdata           : right-justified store data
//   rdata           : full memory word
//   ld_data_s       : lane-selected, sign/zero-extended load result
//   st_data_s       : store data replicated across all lanes
//   st_strb_s       : byte write strobes for the store
module lsa_lane_fmt
   import lsa_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int NLANE = NBITS / 8,
   parameter int OFFW  = $clog2(NLANE)
) (
   input  logic [1:0]       size,
   input  logic             sign,
   input  logic [OFFW-1:0]  off,
   input  logic [NBITS-1:0] wdata,
   input  logic [NBITS-1:0] rdata,
   output logic [NBITS-1:0] ld_data_s,
   output logic [NBITS-1:0] st_data_s,
   output logic [NLANE-1:0] st_strb_s
);

   logic [NBITS-1:0] shifted_s;

   // Load path: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted_s = rdata >> {off, 3'b000};
      case (size)
         SZ_BYTE: ld_data_s = sign ? NBITS'($signed(shifted_s[7:0]))  : NBITS'(shifted_s[7:0]);
         SZ_HALF: ld_data_s = sign ? NBITS'($signed(shifted_s[15:0])) : NBITS'(shifted_s[15:0]);
         SZ_WORD: ld_data_s = sign ? NBITS'($signed(shifted_s[31:0])) : NBITS'(shifted_s[31:0]);
         default: ld_data_s = {NBITS{1'b0}};
      endcase
   end

   // Store path: replicate the datum so whichever lane the strobe selects holds it.
   always_comb begin
      case (size)
         SZ_BYTE: begin
            st_data_s = {NLANE{wdata[7:0]}};
            st_strb_s = NLANE'(4'b0001) << off;
         end
         SZ_HALF: begin
            st_data_s = {(NLANE/2){wdata[15:0]}};
            st_strb_s = NLANE'(4'b0011) << off;
         end
         SZ_WORD: begin
            st_data_s = {(NLANE/4){wdata[31:0]}};
            st_strb_s = NLANE'(4'b1111) << off;
         end
         default: begin
            st_data_s = {NBITS{1'b0}};
            st_strb_s = {NLANE{1'b0}};
         end
      endcase
   end

endmodule

// File: rtl/load_store_aligner.sv
// load_store_aligner: registered load/store formatting unit (IDLE/MEM/RESP).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : request, memory and response signals, all outputs registered
// Illegal accesses (size 00, odd halfword, unaligned word) answer with err=1
// one cycle after accept and never touch memory.
// Build option LSA_ERR_COUNT_EN: saturating count of error responses delivered.
module load_store_aligner
   import lsa_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int AW    = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   load_store_aligner_if.slave   bus
);
   localparam int NLANE = NBITS / 8;
   localparam int OFFW  = $clog2(NLANE);

   state_t           state_r, state_nx;
   logic [1:0]       size_r, size_nx;
   logic             sign_r, sign_nx;
   logic             we_r, we_nx;
   logic [OFFW-1:0]  off_r, off_nx;
   logic             ready_r, ready_nx;
   logic             mem_en_r, mem_en_nx;
   logic [NLANE-1:0] mem_we_r, mem_we_nx;
   logic [AW-1:0]    mem_addr_r, mem_addr_nx;
   logic [NBITS-1:0] mem_wdata_r, mem_wdata_nx;
   logic             rsp_valid_r, rsp_valid_nx;
   logic [NBITS-1:0] rsp_rdata_r, rsp_rdata_nx;
   logic             rsp_err_r, rsp_err_nx;

   logic [1:0]       fmt_size_s;
   logic [OFFW-1:0]  fmt_off_s;
   logic [NBITS-1:0] ld_data_s, st_data_s;
   logic [NLANE-1:0] st_strb_s;

   // Formatter sees the live request while idle (store setup) and the latched one afterwards (load result).
   always_comb begin
      if (state_r == ST_IDLE) begin
         fmt_size_s = bus.i_req_size;
         fmt_off_s  = bus.i_req_addr[OFFW-1:0];
      end else begin
         fmt_size_s = size_r;
         fmt_off_s  = off_r;
      end
   end

   lsa_lane_fmt #(.NBITS(NBITS)) u_fmt (
      .size      (fmt_size_s),
      .sign      (sign_r),
      .off       (fmt_off_s),
      .wdata     (bus.i_req_wdata),
      .rdata     (bus.i_mem_rdata),
      .ld_data_s (ld_data_s),
      .st_data_s (st_data_s),
      .st_strb_s (st_strb_s)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state_r;
      size_nx      = size_r;
      sign_nx      = sign_r;
      we_nx        = we_r;
      off_nx       = off_r;
      ready_nx     = ready_r;
      mem_en_nx    = mem_en_r;
      mem_we_nx    = mem_we_r;
      mem_addr_nx  = mem_addr_r;
      mem_wdata_nx = mem_wdata_r;
      rsp_valid_nx = rsp_valid_r;
      rsp_rdata_nx = rsp_rdata_r;
      rsp_err_nx   = rsp_err_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.i_req_valid) begin
               size_nx  = bus.i_req_size;
               sign_nx  = bus.i_req_sign;
               we_nx    = bus.i_req_we;
               off_nx   = bus.i_req_addr[OFFW-1:0];
               ready_nx = 1'b0;
               if (is_misaligned(bus.i_req_size, 3'(bus.i_req_addr[OFFW-1:0]))) begin
                  state_nx     = ST_RESP;
                  rsp_valid_nx = 1'b1;
                  rsp_err_nx   = 1'b1;
                  rsp_rdata_nx = {NBITS{1'b0}};
               end else begin
                  state_nx     = ST_MEM;
                  mem_en_nx    = 1'b1;
                  mem_addr_nx  = {bus.i_req_addr[AW-1:OFFW], {OFFW{1'b0}}};
                  mem_we_nx    = bus.i_req_we ? st_strb_s : {NLANE{1'b0}};
                  mem_wdata_nx = bus.i_req_we ? st_data_s : {NBITS{1'b0}};
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_MEM: begin
            if (bus.i_mem_ack) begin
               state_nx     = ST_RESP;
               mem_en_nx    = 1'b0;
               mem_we_nx    = {NLANE{1'b0}};
               rsp_valid_nx = 1'b1;
               rsp_err_nx   = 1'b0;
               rsp_rdata_nx = we_r ? {NBITS{1'b0}} : ld_data_s;
            end else begin
               state_nx = ST_MEM;
            end
         end
         ST_RESP: begin
            if (bus.i_rsp_ready) begin
               state_nx     = ST_IDLE;
               ready_nx     = 1'b1;
               rsp_valid_nx = 1'b0;
               rsp_err_nx   = 1'b0;
               rsp_rdata_nx = {NBITS{1'b0}};
            end else begin
               state_nx = ST_RESP;
            end
         end
         default: begin
            state_nx     = ST_IDLE;
            ready_nx     = 1'b1;
            mem_en_nx    = 1'b0;
            mem_we_nx    = {NLANE{1'b0}};
            rsp_valid_nx = 1'b0;
            rsp_err_nx   = 1'b0;
            rsp_rdata_nx = {NBITS{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r     <= ST_IDLE;
         size_r      <= 2'b00;
         sign_r      <= 1'b0;
         we_r        <= 1'b0;
         off_r       <= {OFFW{1'b0}};
         ready_r     <= 1'b1;
         mem_en_r    <= 1'b0;
         mem_we_r    <= {NLANE{1'b0}};
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {NBITS{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {NBITS{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nx;
         size_r      <= size_nx;
         sign_r      <= sign_nx;
         we_r        <= we_nx;
         off_r       <= off_nx;
         ready_r     <= ready_nx;
         mem_en_r    <= mem_en_nx;
         mem_we_r    <= mem_we_nx;
         mem_addr_r  <= mem_addr_nx;
         mem_wdata_r <= mem_wdata_nx;
         rsp_valid_r <= rsp_valid_nx;
         rsp_rdata_r <= rsp_rdata_nx;
         rsp_err_r   <= rsp_err_nx;
      end
   end

   assign bus.o_req_ready = ready_r;
   assign bus.o_mem_en    = mem_en_r;
   assign bus.o_mem_we    = mem_we_r;
   assign bus.o_mem_addr  = mem_addr_r;
   assign bus.o_mem_wdata = mem_wdata_r;
   assign bus.o_rsp_valid = rsp_valid_r;
   assign bus.o_rsp_rdata = rsp_rdata_r;
   assign bus.o_rsp_err   = rsp_err_r;

`ifdef LSA_ERR_COUNT_EN
   logic [15:0] err_count_r;

   // Saturating count of error responses actually handed over.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         err_count_r <= 16'h0000;
      end else if (rsp_valid_r && bus.i_rsp_ready && rsp_err_r && (err_count_r != 16'hFFFF)) begin
         err_count_r <= err_count_r + 16'h0001;
      end else begin
         err_count_r <= err_count_r;
      end
   end

   assign bus.o_err_count = err_count_r;
`endif

endmodule

// File: doc/load_store_aligner.md
Name: load_store_aligner

Overview:
- Registered load/store formatting unit between the MEM-stage request and data memory.
- Accepts one byte/halfword/word access per transaction through a valid/ready handshake.
- Loads: issues a word-aligned memory access, then lane-selects and sign/zero-extends the result.
- Stores: replicates write data across lanes and generates byte strobes. Misaligned or invalid-size accesses are flagged as errors and never reach memory.

Parameters:
- NBITS, 32, datapath width; legal values 32 or 64.
- AW, 32, byte-address width.
- NLANE, NBITS/8, derived byte-lane count (localparam).
- OFFW, $clog2(NLANE), derived lane-offset width (localparam).

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit idle, can accept a request
- i_req_we  in  1  1=store, 0=load
- i_req_addr  in  AW  byte address
- i_req_size  in  2  01=byte, 10=halfword, 11=word(32b), 00=invalid
- i_req_sign  in  1  1=sign-extend load, 0=zero-extend
- i_req_wdata  in  NBITS  store data, right-justified
- o_mem_en  out  1  memory access strobe, held until ack
- o_mem_we  out  NLANE  byte write strobes; all 0 for loads
- o_mem_addr  out  AW  lane-aligned address (low OFFW bits = 0)
- o_mem_wdata  out  NBITS  lane-replicated store data
- i_mem_ack  in  1  memory completion
- i_mem_rdata  in  NBITS  memory read data, valid with ack
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_rdata  out  NBITS  formatted load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned or invalid-size access

Behaviour:
- Reset: synchronous, active-low.
  - All outputs 0 except o_req_ready=1; state IDLE.
  - Reset mid-transaction abandons it; o_mem_en and o_rsp_valid are 0 from the cycle after the reset edge.
- FSM states: IDLE, MEM, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch all request fields.
  - If the access is illegal, go to RESP with err=1 and rdata=0; no memory access.
  - Illegal means any of: size=00, halfword with addr[0]=1, word with addr[1:0]≠0.
  - Otherwise go to MEM.
- MEM:
  - o_mem_en=1; o_mem_addr, o_mem_we and o_mem_wdata stay stable until i_mem_ack.
  - i_mem_ack is sampled every MEM cycle, including the first.
  - On ack: register the formatted result and go to RESP.
  - Memory latency is unbounded; no timeout.
- RESP:
  - o_rsp_valid=1; rdata and err stay stable until i_rsp_ready.
  - On i_rsp_ready, go to IDLE. The next request is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- i_mem_ack outside MEM: ignored.
- Lane ordering: little-endian; lane index = addr[OFFW-1:0].
- Store formatting:
  - byte: wdata[7:0] replicated to all lanes; strobe 1<<off.
  - half: wdata[15:0] replicated; strobe 2'b11<<off.
  - word: wdata[31:0] replicated; strobe 4'hF<<off.
- Load formatting:
  - Shift i_mem_rdata right by off*8, then take the low 8, 16 or 32 bits.
  - With i_req_sign=1, replicate the top bit of that field to NBITS; with i_req_sign=0, zero-fill.
  - For word loads with NBITS=32, extension is a no-op.
- Latency: accept at cycle 0, o_mem_en at cycle 1, ack at cycle N≥1, o_rsp_valid at cycle N+1.
  - Illegal access: o_rsp_valid at cycle 1.

Optional Feature:
- Macro: LSA_ERR_COUNT_EN.
- Defined:
  - Adds output o_err_count [15:0], a saturating count of responses delivered with err=1.
  - Increments on o_rsp_valid & i_rsp_ready & o_rsp_err; holds at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lsa_pkg holds:
  - size encodings SZ_BYTE=2'b01, SZ_HALF=2'b10, SZ_WORD=2'b11;
  - state encodings;
  - function is_misaligned(size, off).
- Sub-module lsa_lane_fmt (combinational):
  - load extract/extend and store replicate/strobe;
  - instantiated once; the FSM wrapper holds all registers.

Test Plan:
- Signed byte load: addr=0x1003, size=01, sign=1, ack after 2 cycles with rdata=0x80FF_1234 -> o_mem_addr=0x1000, o_mem_we=0, o_rsp_rdata=0xFFFF_FF80, err=0; o_rsp_valid 3 cycles after accept.
- Zero-extended half load: addr=0x2002, size=10, sign=0, rdata=0x8001_0000 -> o_rsp_rdata=0x0000_8001.
- Store byte: addr=0x3001, size=01, wdata=0x0000_00AB -> o_mem_we=4'b0010, o_mem_wdata=0xABAB_ABAB; o_rsp_rdata=0.
- Misaligned word at addr=0x4002, then size=00 at addr=0x4000 -> o_mem_en never asserts; o_rsp_err=1 at cycle 1 each. With LSA_ERR_COUNT_EN, o_err_count=2.
- Backpressure: i_rsp_ready held low 5 cycles -> o_rsp_valid and data stable; o_req_ready=0 throughout; a stray i_mem_ack in RESP has no effect.
- Reset in MEM: assert i_rst_n=0 for one edge while o_mem_en=1 -> next cycle o_mem_en=0, o_req_ready=1; a later ack is ignored.
